// File: rtl/axi_cmd_arbiter.sv
// Round-robin arbiter that shares the single axi_master command port among NUM_REQ requesters.
// Exactly one transaction is outstanding; ownership is held until the B or R channel completes.
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

module axi_cmd_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                                  aclk,
    input  logic                                  areset,
    input  logic [NUM_REQ-1:0]                    req_valid,
    input  logic [NUM_REQ-1:0]                    req_write,
    input  logic [NUM_REQ*`AXI_ADDR_W-1:0]        req_addr,
    input  logic [NUM_REQ*`AXI_ID_W-1:0]          req_id,
    input  logic [NUM_REQ*`AXI_LEN_W-1:0]         req_len,
    input  logic [NUM_REQ*`AXI_SIZE_W-1:0]        req_size,
    input  logic [NUM_REQ*`AXI_BURST_W-1:0]       req_burst,
    input  logic [NUM_REQ*`AXI_DATA_W-1:0]        req_wdata,
    input  logic [NUM_REQ*(`AXI_DATA_W/8)-1:0]    req_wstrb,
    output logic [NUM_REQ-1:0]                    req_ack,
    output logic [NUM_REQ-1:0]                    req_done,
    output logic [`AXI_RESP_W-1:0]                req_resp,
    output logic [NUM_REQ-1:0]                    req_rvalid,
    output logic [`AXI_DATA_W-1:0]                req_rdata,
    output logic [NUM_REQ-1:0]                    grant,
    output logic                                  transfer,
    output logic                                  write_en,
    output logic                                  read_en,
    output logic [`AXI_ADDR_W-1:0]                write_addr,
    output logic [`AXI_ID_W-1:0]                  write_id,
    output logic [`AXI_LEN_W-1:0]                 write_len,
    output logic [`AXI_SIZE_W-1:0]                write_size,
    output logic [`AXI_BURST_W-1:0]               write_burst,
    output logic [`AXI_ADDR_W-1:0]                read_addr,
    output logic [`AXI_ID_W-1:0]                  read_id,
    output logic [`AXI_LEN_W-1:0]                 read_len,
    output logic [`AXI_SIZE_W-1:0]                read_size,
    output logic [`AXI_BURST_W-1:0]               read_burst,
    output logic [`AXI_DATA_W-1:0]                write_data,
    output logic [`AXI_DATA_W/8-1:0]              write_strb,
    input  logic                                  bvalid,
    input  logic                                  bready,
    input  logic [`AXI_RESP_W-1:0]                bresp,
    input  logic                                  rvalid,
    input  logic                                  rready,
    input  logic                                  rlast,
    input  logic [`AXI_RESP_W-1:0]                rresp,
    input  logic                                  read_data_out_valid,
    input  logic [`AXI_DATA_W-1:0]                read_data_out
);
    localparam int AW    = `AXI_ADDR_W;
    localparam int IW    = `AXI_ID_W;
    localparam int LW    = `AXI_LEN_W;
    localparam int ZW    = `AXI_SIZE_W;
    localparam int BW    = `AXI_BURST_W;
    localparam int DW    = `AXI_DATA_W;
    localparam int SW    = `AXI_DATA_W / 8;
    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   rr_ptr, owner, win_c;
    logic               win_found, win_wr, owner_wr, complete;
    logic [`AXI_RESP_W-1:0] resp_q;

    function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] base, input int k);
        return PTR_W'((int'(base) + k) % NUM_REQ);
    endfunction

    // Search starts just past the previous owner, so it has the lowest priority next round.
    always_comb begin
        win_found = 1'b0;
        win_c     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!win_found && req_valid[rr_idx(rr_ptr, k)]) begin
                win_found = 1'b1;
                win_c     = rr_idx(rr_ptr, k);
            end
        end
    end

    assign win_wr   = req_write[win_c];
    // A nonzero rresp ends the read early because axi_master abandons the burst on it.
    assign complete = owner_wr ? (bvalid && bready)
                               : (rvalid && rready && (rlast || rresp != '0));

    always_ff @(posedge aclk) begin
        if (areset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_found) state_nxt = ISSUE;
            ISSUE:   state_nxt = BUSY;
            BUSY:    if (complete) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            grant       <= '0;
            rr_ptr      <= PTR_W'(NUM_REQ - 1);
            owner       <= '0;
            owner_wr    <= 1'b0;
            resp_q      <= '0;
            write_addr  <= '0;
            write_id    <= '0;
            write_len   <= '0;
            write_size  <= '0;
            write_burst <= '0;
            read_addr   <= '0;
            read_id     <= '0;
            read_len    <= '0;
            read_size   <= '0;
            read_burst  <= '0;
        end else begin
            case (state)
                IDLE: if (win_found) begin
                    grant       <= NUM_REQ'(1) << win_c;
                    owner       <= win_c;
                    owner_wr    <= win_wr;
                    write_addr  <= win_wr ? req_addr[win_c*AW +: AW]   : '0;
                    write_id    <= win_wr ? req_id[win_c*IW +: IW]     : '0;
                    write_len   <= win_wr ? req_len[win_c*LW +: LW]    : '0;
                    write_size  <= win_wr ? req_size[win_c*ZW +: ZW]   : '0;
                    write_burst <= win_wr ? req_burst[win_c*BW +: BW]  : '0;
                    read_addr   <= win_wr ? '0 : req_addr[win_c*AW +: AW];
                    read_id     <= win_wr ? '0 : req_id[win_c*IW +: IW];
                    read_len    <= win_wr ? '0 : req_len[win_c*LW +: LW];
                    read_size   <= win_wr ? '0 : req_size[win_c*ZW +: ZW];
                    read_burst  <= win_wr ? '0 : req_burst[win_c*BW +: BW];
                end
                BUSY: if (complete) resp_q <= owner_wr ? bresp : rresp;
                DONE: begin
                    grant  <= '0;
                    rr_ptr <= owner;
                end
                default: ;
            endcase
        end
    end

    assign transfer   = (state == ISSUE);
    assign write_en   = transfer && owner_wr;
    assign read_en    = transfer && !owner_wr;
    assign req_ack    = transfer ? grant : '0;
    assign req_done   = (state == DONE) ? grant : '0;
    assign req_resp   = (state == DONE) ? resp_q : '0;
    assign req_rvalid = grant & {NUM_REQ{read_data_out_valid}};
    assign req_rdata  = read_data_out;

    always_comb begin
        write_data = '0;
        write_strb = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                write_data = req_wdata[i*DW +: DW];
                write_strb = req_wstrb[i*SW +: SW];
            end
        end
    end

endmodule

// File: tb/tb_axi_cmd_arbiter.sv
// Bench for axi_cmd_arbiter: table of single transactions, fairness rotation and reset mid-burst,
// with a behavioural AXI slave and an ack/done scoreboard.
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

module tb_axi_cmd_arbiter;
    localparam int N  = 4;
    localparam int AW = `AXI_ADDR_W;
    localparam int IW = `AXI_ID_W;
    localparam int LW = `AXI_LEN_W;
    localparam int ZW = `AXI_SIZE_W;
    localparam int BW = `AXI_BURST_W;
    localparam int DW = `AXI_DATA_W;
    localparam int SW = `AXI_DATA_W / 8;
    localparam int RW = `AXI_RESP_W;

    logic aclk = 1'b0;
    logic areset;
    logic [N-1:0]    req_valid, req_write, req_ack, req_done, req_rvalid, grant;
    logic [N*AW-1:0] req_addr;
    logic [N*IW-1:0] req_id;
    logic [N*LW-1:0] req_len;
    logic [N*ZW-1:0] req_size;
    logic [N*BW-1:0] req_burst;
    logic [N*DW-1:0] req_wdata;
    logic [N*SW-1:0] req_wstrb;
    logic [RW-1:0]   req_resp, bresp, rresp;
    logic [DW-1:0]   req_rdata, write_data, read_data_out;
    logic [SW-1:0]   write_strb;
    logic            transfer, write_en, read_en;
    logic [AW-1:0]   write_addr, read_addr;
    logic [IW-1:0]   write_id, read_id;
    logic [LW-1:0]   write_len, read_len;
    logic [ZW-1:0]   write_size, read_size;
    logic [BW-1:0]   write_burst, read_burst;
    logic            bvalid, bready, rvalid, rready, rlast, read_data_out_valid;

    always #5 aclk = ~aclk;

    axi_cmd_arbiter #(.NUM_REQ(N)) dut (
        .aclk(aclk), .areset(areset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_id(req_id),
        .req_len(req_len), .req_size(req_size), .req_burst(req_burst),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .req_ack(req_ack), .req_done(req_done), .req_resp(req_resp),
        .req_rvalid(req_rvalid), .req_rdata(req_rdata), .grant(grant),
        .transfer(transfer), .write_en(write_en), .read_en(read_en),
        .write_addr(write_addr), .write_id(write_id), .write_len(write_len),
        .write_size(write_size), .write_burst(write_burst),
        .read_addr(read_addr), .read_id(read_id), .read_len(read_len),
        .read_size(read_size), .read_burst(read_burst),
        .write_data(write_data), .write_strb(write_strb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .rvalid(rvalid), .rready(rready), .rlast(rlast), .rresp(rresp),
        .read_data_out_valid(read_data_out_valid), .read_data_out(read_data_out)
    );

    typedef struct {
        int           req;
        logic         wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic [RW-1:0] sresp;
        int           err_beat;
        logic [RW-1:0] exp_resp;
        int           exp_beats;
    } vec_t;

    typedef struct {
        int           req;
        logic         wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic [RW-1:0] resp;
    } exp_t;

    exp_t ack_q[$];
    exp_t done_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int ack_cnt  = 0;
    int rv_cnt[N];

    logic          slave_en;
    logic [RW-1:0] s_resp;
    int            s_err;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [DW-1:0] wdata_of(input int i);
        return DW'(32'hCAFE_0000 + i);
    endfunction

    always @(posedge aclk) cyc <= cyc + 1;

    // Behavioural slave: answers each transfer with B or R beats after the ISSUE cycle.
    initial begin
        int L;
        bvalid = 0; bready = 0; bresp = '0;
        rvalid = 0; rready = 0; rlast = 0; rresp = '0;
        read_data_out_valid = 0; read_data_out = '0;
        forever begin
            @(posedge aclk); #1;
            if (slave_en && transfer && !areset) begin
                if (write_en) begin
                    L = int'(write_len);
                    repeat (L + 1) begin @(posedge aclk); #1; end
                    bvalid = 1; bready = 1; bresp = s_resp;
                    @(posedge aclk); #1;
                    bvalid = 0; bready = 0; bresp = '0;
                end else begin
                    L = int'(read_len);
                    @(posedge aclk); #1;
                    for (int b = 0; b <= L; b++) begin
                        rvalid = 1; rready = 1; rlast = (b == L);
                        rresp = (b == s_err) ? s_resp : '0;
                        read_data_out_valid = 1;
                        read_data_out = DW'(32'hD000_0000 + b);
                        @(posedge aclk); #1;
                        if (b == s_err) break;
                    end
                    rvalid = 0; rready = 0; rlast = 0; rresp = '0;
                    read_data_out_valid = 0; read_data_out = '0;
                end
            end
        end
    end

    // Monitor / scoreboard, sampled on the falling edge.
    initial begin
        exp_t cur, e;
        logic cur_vld, post_done, compl_prev;
        int   last_xfer;
        cur_vld = 0; post_done = 0; compl_prev = 0; last_xfer = -100;
        for (int i = 0; i < N; i++) rv_cnt[i] = 0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                cur_vld = 0; post_done = 0; compl_prev = 0;
                done_q.delete();
            end else begin
                if (post_done) chk("grant_idle_after_done", grant, 0);
                post_done = 0;
                if (req_ack != 0) begin
                    ack_cnt++;
                    chk("transfer_with_ack", transfer, 1);
                    chk("transfer_spacing_ge4", (cyc - last_xfer) >= 4, 1);
                    last_xfer = cyc;
                    if (ack_q.size() == 0) chk("unexpected_ack", req_ack, 0);
                    else begin
                        cur = ack_q.pop_front();
                        cur_vld = 1;
                        done_q.push_back(cur);
                        chk("ack_onehot", req_ack, 1 << cur.req);
                        chk("write_en", write_en, cur.wr);
                        chk("read_en", read_en, !cur.wr);
                        chk("wdata_mux", write_data, wdata_of(cur.req));
                        chk("wstrb_mux", write_strb, cur.req + 1);
                    end
                end else if (transfer) chk("transfer_without_ack", transfer, 0);
                if (cur_vld) begin
                    chk("grant_owner", grant, 1 << cur.req);
                    if (cur.wr) begin
                        chk("write_addr", write_addr, cur.addr);
                        chk("write_len", write_len, cur.len);
                        chk("read_addr_zero", read_addr, 0);
                    end else begin
                        chk("read_addr", read_addr, cur.addr);
                        chk("read_len", read_len, cur.len);
                        chk("write_addr_zero", write_addr, 0);
                    end
                end
                if (compl_prev) chk("done_after_completion", req_done != 0, 1);
                if (req_done != 0) begin
                    chk("done_one_cycle_after_completion", compl_prev, 1);
                    if (done_q.size() == 0) chk("unexpected_done", req_done, 0);
                    else begin
                        e = done_q.pop_front();
                        chk("done_onehot", req_done, 1 << e.req);
                        chk("req_resp", req_resp, e.resp);
                    end
                    cur_vld = 0;
                    post_done = 1;
                end
                if (req_rvalid != 0) begin
                    if (cur_vld) chk("rvalid_owner", req_rvalid, 1 << cur.req);
                    else chk("rvalid_idle", req_rvalid, 0);
                    chk("rdata_pass", req_rdata, read_data_out);
                    for (int i = 0; i < N; i++) rv_cnt[i] += int'(req_rvalid[i]);
                end
                compl_prev = (grant != 0) && ((bvalid && bready) ||
                             (rvalid && rready && (rlast || rresp != 0)));
            end
        end
    end

    task automatic wait_ack(input int r);
        logic seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin @(negedge aclk); seen = req_ack[r]; end
        chk("ack_seen", seen, 1);
        @(posedge aclk); #1;
    endtask

    task automatic wait_done(input int r);
        logic seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin @(negedge aclk); seen = req_done[r]; end
        chk("done_seen", seen, 1);
        @(posedge aclk); #1;
    endtask

    task automatic set_req(input int r, input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] l);
        req_write[r] = wr;
        req_addr[r*AW +: AW] = a;
        req_len[r*LW +: LW] = l;
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   base[N];
        int   others;
        e.req = v.req; e.wr = v.wr; e.addr = v.addr; e.len = v.len; e.resp = v.exp_resp;
        s_resp = v.sresp; s_err = v.err_beat;
        for (int i = 0; i < N; i++) base[i] = rv_cnt[i];
        set_req(v.req, v.wr, v.addr, v.len);
        ack_q.push_back(e);
        req_valid[v.req] = 1;
        wait_ack(v.req);
        req_valid[v.req] = 0;
        wait_done(v.req);
        chk("rvalid_beats", rv_cnt[v.req] - base[v.req], v.exp_beats);
        others = 0;
        for (int i = 0; i < N; i++) if (i != v.req) others += rv_cnt[i] - base[i];
        chk("rvalid_others_zero", others, 0);
    endtask

    initial begin
        vec_t vecs[6];
        exp_t e;
        int   a0;
        logic seen;
        req_valid = '0; req_write = '0; req_addr = '0; req_len = '0;
        slave_en = 1; s_resp = '0; s_err = -1;
        for (int i = 0; i < N; i++) begin
            req_id[i*IW +: IW]       = IW'(i);
            req_size[i*ZW +: ZW]     = ZW'(2);
            req_burst[i*BW +: BW]    = BW'(1);
            req_wdata[i*DW +: DW]    = wdata_of(i);
            req_wstrb[i*SW +: SW]    = SW'(i + 1);
        end
        areset = 1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_grant", grant, 0);
        chk("rst_transfer", transfer, 0);
        chk("rst_ack_done", {req_ack, req_done}, 0);
        chk("rst_write_data", write_data, 0);
        chk("rst_fields", {write_addr, read_addr}, 0);
        @(posedge aclk); #1;
        areset = 0;

        vecs[0] = '{req:2, wr:1'b1, addr:32'h40,  len:8'd3, sresp:2'b00, err_beat:-1, exp_resp:2'b00, exp_beats:0};
        vecs[1] = '{req:1, wr:1'b0, addr:32'h80,  len:8'd7, sresp:2'b00, err_beat:-1, exp_resp:2'b00, exp_beats:8};
        vecs[2] = '{req:0, wr:1'b0, addr:32'hC0,  len:8'd3, sresp:2'b10, err_beat:0,  exp_resp:2'b10, exp_beats:1};
        vecs[3] = '{req:3, wr:1'b1, addr:32'h100, len:8'd1, sresp:2'b11, err_beat:-1, exp_resp:2'b11, exp_beats:0};
        vecs[4] = '{req:1, wr:1'b1, addr:32'h10,  len:8'd0, sresp:2'b00, err_beat:-1, exp_resp:2'b00, exp_beats:0};
        vecs[5] = '{req:3, wr:1'b0, addr:32'h20,  len:8'd0, sresp:2'b01, err_beat:0,  exp_resp:2'b01, exp_beats:1};
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Fairness: everyone valid, grants must rotate from just past the last owner (3).
        s_resp = '0; s_err = -1;
        for (int i = 0; i < N; i++) set_req(i, i[0], AW'(32'h1000 + i * 32'h100), 8'd1);
        for (int k = 0; k < 6; k++) begin
            e.req = k % N; e.wr = e.req[0]; e.addr = AW'(32'h1000 + e.req * 32'h100);
            e.len = 8'd1; e.resp = '0;
            ack_q.push_back(e);
        end
        a0 = ack_cnt;
        req_valid = '1;
        for (int c = 0; c < 400 && (ack_cnt - a0) < 6; c++) @(negedge aclk);
        chk("fair_ack_count", ack_cnt - a0, 6);
        @(posedge aclk); #1;
        req_valid = '0;
        wait_done(1);

        // Reset during a write burst with the slave silent.
        slave_en = 0;
        set_req(2, 1'b1, 32'h200, 8'd7);
        e.req = 2; e.wr = 1; e.addr = 32'h200; e.len = 8'd7; e.resp = '0;
        ack_q.push_back(e);
        req_valid[2] = 1;
        wait_ack(2);
        req_valid[2] = 0;
        @(posedge aclk); #1;
        areset = 1;
        set_req(0, 1'b0, 32'h300, 8'd0);
        set_req(3, 1'b1, 32'h340, 8'd0);
        e.req = 0; e.wr = 0; e.addr = 32'h300; e.len = 8'd0; ack_q.push_back(e);
        e.req = 3; e.wr = 1; e.addr = 32'h340; e.len = 8'd0; ack_q.push_back(e);
        req_valid[0] = 1; req_valid[3] = 1;
        @(posedge aclk); #1;
        areset = 0;
        slave_en = 1;
        @(negedge aclk);
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_strobes", {transfer, write_en, read_en}, 0);
        chk("mid_rst_ack_done_resp", {req_ack, req_done, req_resp}, 0);
        chk("mid_rst_fields", {write_addr, write_len, read_addr, read_len}, 0);
        chk("mid_rst_wdata", {write_data, write_strb}, 0);
        wait_ack(0);
        req_valid[0] = 0;
        wait_done(0);
        wait_ack(3);
        req_valid[3] = 0;
        wait_done(3);
        seen = (ack_q.size() == 0);
        chk("scoreboard_drained", seen, 1);

        repeat (3) @(posedge aclk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_cmd_arbiter.md
# axi_cmd_arbiter

Round-robin arbiter and sequencer that shares the single command interface of `axi_master` between NUM_REQ requesters. It grants one requester at a time and registers that requester's command fields. It pulses `transfer` with `write_en` or `read_en`, then holds ownership until the transaction completes. Completion is detected by monitoring the AXI B and R channel handshakes. Exactly one transaction is outstanding at any time.

## Interface
- NUM_REQ, 4, number of requesters; range 2..16.
- Field widths (ADDR, ID, LEN, SIZE, BURST, DATA, RESP) come from the global `axi_config` macros. Below, `W` denotes the per-requester slice width of each packed vector.
- aclk  in  1  system clock; all state updates on its rising edge.
- areset  in  1  reset; one clock; synchronous, active-high.
- req_valid  in  NUM_REQ  requester i has a pending command; held until its req_ack.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr / req_id / req_len / req_size / req_burst  in  NUM_REQ*W  packed command fields.
- req_wdata / req_wstrb  in  NUM_REQ*W  per-beat write data and strobes; forwarded combinationally from the granted requester.
- req_ack  out  NUM_REQ  one-cycle pulse when the command is issued.
- req_done  out  NUM_REQ  one-cycle pulse when the transaction completes.
- req_resp  out  RESP  response code; valid only while any req_done bit is high.
- req_rvalid  out  NUM_REQ  read_data_out_valid AND grant[i].
- req_rdata  out  DATA  read_data_out, passed through unchanged.
- grant  out  NUM_REQ  one-hot owner; 0 when idle.
- transfer, write_en, read_en  out  1  command strobes to axi_master.
- write_addr/id/len/size/burst, read_addr/id/len/size/burst  out  W  registered command fields to axi_master.
- write_data / write_strb  out  W  mux of req_wdata / req_wstrb by grant.
- bvalid, bready, bresp, rvalid, rready, rlast, rresp  in  monitor taps on the AXI B and R channels.

## Operation
- FSM states:
  - IDLE: if any req_valid is set, pick winner w (round-robin), register grant=onehot(w), latch w's fields, and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE (exactly 1 cycle): transfer=1; write_en=req_write[w], read_en=~req_write[w]; req_ack[w]=1. Next state is BUSY.
  - BUSY: wait for completion.
    - Write completes on bvalid&&bready.
    - Read completes on rvalid&&rready&&(rlast || rresp!=0). A nonzero rresp is included because axi_master abandons the read on an error beat.
    - On completion: latch resp (bresp or rresp of that beat), next state DONE.
  - DONE (1 cycle): req_done[w]=1, req_resp=latched resp; rr_ptr<=w; grant<=0; next state IDLE.
- Round-robin: search order is rr_ptr+1, rr_ptr+2, … modulo NUM_REQ. rr_ptr resets to NUM_REQ-1, so requester 0 wins the first arbitration.
- Command fields for both write_* and read_* ports are loaded from the winner at grant. They stay stable from ISSUE through DONE, because axi_master samples them combinationally while in its ADDR state. The unused direction's fields are driven 0.
- write_data / write_strb: driven from the granted requester while grant≠0, and 0 when idle.
- req_valid of non-granted requesters is ignored while busy. Any deassertion of req_valid[w] after grant is ignored; the transaction always runs to completion.
- Reset (synchronous, any state, including mid-BUSY):
  - state=IDLE, grant=0, rr_ptr=NUM_REQ-1.
  - All outputs 0: transfer, write_en, read_en, req_ack, req_done, req_resp, all command fields, write_data, write_strb.
  - The system must reset axi_master in the same cycle; the arbiter does not track an orphaned transaction.

## Timing
- Cycle 0: IDLE samples req_valid. Cycle 1: ISSUE, with transfer/ack pulses. Cycle 2 onward: BUSY.
- If completion is seen in cycle n, DONE (req_done) is asserted in cycle n+1. Arbitration of the next request happens in cycle n+2 (IDLE), so the next transfer pulse is at n+3.
- Minimum spacing between transfer pulses: 4 cycles.
- transfer is never asserted outside ISSUE; exactly one transfer per ack.
- req_rvalid/req_rdata are combinational (zero added latency). They may pulse multiple times per read burst.
- Simultaneous request from the just-finished owner and others: the owner has the lowest priority next round.
- All requesters valid continuously: grants rotate 0,1,2,3,0,…

## Test plan
- Single write: req 2 issues write, len=3, addr=0x40, bresp=OKAY.
  - Expect grant=0100 from cycle 1 to DONE, one transfer with write_en=1, write_addr=0x40 held stable, req_ack[2] then req_done[2] with resp=00.
- Fairness: all 4 req_valid held high, alternating read/write, slave responding with bresp=OKAY / rlast.
  - Expect grant order 0,1,2,3,0,1; no requester served twice before all others are served.
- Read burst: req 1 reads len=7.
  - Expect 8 req_rvalid[1] pulses carrying slave rdata and no other req_rvalid bits; req_done[1] one cycle after the rlast beat.
- Read error: slave returns rresp=SLVERR on beat 0 of len=3.
  - Expect completion on that beat, req_done with resp=10, then a return to IDLE.
- Write error: bresp=DECERR. Expect req_resp=11 during req_done.
- Reset mid-BUSY: assert areset during a write burst.
  - Expect grant=0 and all outputs 0 next cycle. After release, requester 0 wins over 3 when both are valid.
